// File: rtl/mips32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_pkg                                                                 |
// | Shared loader/dump FSM states, sticky error codes and MIPS32 opcodes.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mips32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_INIT    = 3'd2,
        ST_RUN     = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_OUT     = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OVF     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [5:0] HLT  = 6'h3f;
    localparam logic [5:0] ADDI = 6'h0a;
    localparam logic [5:0] ADD  = 6'h00;
    localparam logic [5:0] OR   = 6'h03;

endpackage
`default_nettype wire

// File: rtl/mips32_loader_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_loader_dump                                                         |
// | Streams a program into core memory, runs the core, dumps low registers.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips32_loader_dump
    import mips32_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DUMP_CNT    = 6,
    parameter int RUN_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_init,
    output logic              core_run,
    input  logic              core_halted,
    output logic [4:0]        reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [4:0]        out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int                TMR_W      = $clog2(RUN_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;
    localparam logic [4:0]        c_LAST_IDX = 5'(DUMP_CNT - 1);
    localparam logic [TMR_W-1:0]  c_TMR_LAST = TMR_W'(RUN_TIMEOUT - 1);

    state_e             r_state_q,    w_state_d;
    logic [ADDR_W-1:0]  r_addr_q,     w_addr_d;
    logic [1:0]         r_err_q,      w_err_d;
    logic [TMR_W-1:0]   r_tmr_q,      w_tmr_d;
    logic [4:0]         r_idx_q,      w_idx_d;
    logic [31:0]        r_out_data_q, w_out_data_d;
    logic [4:0]         r_out_idx_q,  w_out_idx_d;
    logic               w_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= ST_IDLE;
            r_addr_q     <= '0;
            r_err_q      <= ERR_NONE;
            r_tmr_q      <= '0;
            r_idx_q      <= '0;
            r_out_data_q <= '0;
            r_out_idx_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_addr_q     <= w_addr_d;
            r_err_q      <= w_err_d;
            r_tmr_q      <= w_tmr_d;
            r_idx_q      <= w_idx_d;
            r_out_data_q <= w_out_data_d;
            r_out_idx_q  <= w_out_idx_d;
        end
    end

    assign w_xfer = (r_state_q == ST_LOAD) && in_valid;

    always_comb begin
        w_state_d    = r_state_q;
        w_addr_d     = r_addr_q;
        w_err_d      = r_err_q;
        w_tmr_d      = r_tmr_q;
        w_idx_d      = r_idx_q;
        w_out_data_d = r_out_data_q;
        w_out_idx_d  = r_out_idx_q;
        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_d = ST_LOAD;
                    w_addr_d  = '0;
                    w_err_d   = ERR_NONE;
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    // The address saturates at the top word rather than wrapping.
                    if (r_addr_q != c_ADDR_MAX) begin
                        w_addr_d = r_addr_q + ADDR_W'(1);
                    end
                    if (in_last) begin
                        w_state_d = ST_INIT;
                    end else if (r_addr_q == c_ADDR_MAX) begin
                        w_err_d   = ERR_OVF;
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_INIT: begin
                w_tmr_d   = '0;
                w_state_d = ST_RUN;
            end
            ST_RUN: begin
                if (core_halted) begin
                    w_idx_d   = '0;
                    w_state_d = ST_RD_ADDR;
                end else if (r_tmr_q == c_TMR_LAST) begin
                    w_err_d   = ERR_TIMEOUT;
                    w_idx_d   = '0;
                    w_state_d = ST_RD_ADDR;
                end else begin
                    w_tmr_d = r_tmr_q + TMR_W'(1);
                end
            end
            ST_RD_ADDR: begin
                w_state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_out_data_d = reg_rdata;
                w_out_idx_d  = r_idx_q;
                w_state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (r_idx_q == c_LAST_IDX) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_idx_d   = r_idx_q + 5'd1;
                        w_state_d = ST_RD_ADDR;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from the state so reset forces them low without a clock.
    assign in_ready  = (r_state_q == ST_LOAD);
    assign mem_we    = w_xfer;
    assign mem_addr  = r_addr_q;
    assign mem_wdata = w_xfer ? in_data : 32'd0;
    assign core_init = (r_state_q == ST_INIT);
    assign core_run  = (r_state_q == ST_RUN);
    assign reg_raddr = r_idx_q;
    assign out_valid = (r_state_q == ST_OUT);
    assign out_data  = r_out_data_q;
    assign out_idx   = r_out_idx_q;
    assign busy      = (r_state_q != ST_IDLE) && (r_state_q != ST_DONE);
    assign done      = (r_state_q == ST_DONE);
    assign err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_loader_dump.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_mips32_loader_dump                                                      |
// | Scoreboard bench with a simple MIPS32 core model and random programs.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mips32_loader_dump;
    import mips32_pkg::*;

    localparam int AW = 10;
    localparam int DC = 6;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          start, in_valid, in_last, in_ready, mem_we, core_init, core_run, core_halted;
    logic          out_valid, out_ready, busy, done;
    logic [31:0]   in_data, mem_wdata, reg_rdata, out_data;
    logic [AW-1:0] mem_addr;
    logic [4:0]    reg_raddr, out_idx;
    logic [1:0]    err;

    mips32_loader_dump #(.ADDR_W(AW), .DUMP_CNT(DC), .RUN_TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_init(core_init), .core_run(core_run),
        .core_halted(core_halted), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    // Small-memory instance used only to provoke the overflow path.
    logic          b_start, b_in_valid, b_in_last, b_in_ready, b_mem_we, b_core_init, b_core_run;
    logic          b_out_valid, b_busy, b_done;
    logic [31:0]   b_in_data, b_mem_wdata, b_out_data;
    logic [2:0]    b_mem_addr;
    logic [4:0]    b_reg_raddr, b_out_idx;
    logic [1:0]    b_err;
    logic          b_core_halted = 1'b0;
    logic          b_out_ready   = 1'b1;
    logic [31:0]   b_reg_rdata   = 32'd0;

    mips32_loader_dump #(.ADDR_W(3), .DUMP_CNT(DC), .RUN_TIMEOUT(TO)) u_dut_ovf (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_last(b_in_last), .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .core_init(b_core_init), .core_run(b_core_run),
        .core_halted(b_core_halted), .reg_raddr(b_reg_raddr), .reg_rdata(b_reg_rdata),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_idx(b_out_idx),
        .out_ready(b_out_ready), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Core model: one instruction per cycle while core_run; registers start at zero per program.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] regs [0:31];
    logic [AW-1:0] pc;
    logic halted;
    logic hold_low = 1'b0;
    logic [31:0] cur;
    assign cur = mem[pc];
    assign core_halted = halted & ~hold_low;

    always @(posedge clk) begin
        reg_rdata <= regs[reg_raddr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (!rst_n) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (core_init) begin
            pc     <= '0;
            halted <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (core_run && !halted) begin
            pc <= pc + AW'(1);
            case (cur[31:26])
                HLT:  halted <= 1'b1;
                ADDI: if (cur[20:16] != 5'd0)
                          regs[cur[20:16]] <= regs[cur[25:21]] + {{16{cur[15]}}, cur[15:0]};
                ADD:  if (cur[15:11] != 5'd0) regs[cur[15:11]] <= regs[cur[25:21]] + regs[cur[20:16]];
                OR:   if (cur[15:11] != 5'd0) regs[cur[15:11]] <= regs[cur[25:21]] | regs[cur[20:16]];
                default: ;
            endcase
        end
    end

    typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic [2:0] a; logic [31:0] d; } wrb_t;
    typedef struct packed { logic [4:0] i; logic [31:0] d; } dp_t;
    wr_t  exp_wr[$];
    wrb_t exp_wr_b[$];
    dp_t  exp_dump[$];

    int checks = 0;
    int failures = 0;
    int init_cnt = 0;
    int run_cnt = 0;
    int b_init_cnt = 0;
    logic bp_mode = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=expired required=event", name);
    endfunction

    // Reference: straight-line interpretation of the program until HLT, from zeroed registers.
    function automatic void ref_run(input logic [31:0] prog[$], output logic [31:0] dv[DC]);
        logic [31:0] r[32];
        int rs, rt, rd, dst;
        logic [31:0] val;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        foreach (prog[k]) begin
            rs = int'(prog[k][25:21]);
            rt = int'(prog[k][20:16]);
            rd = int'(prog[k][15:11]);
            dst = 0;
            val = 32'd0;
            if (prog[k][31:26] == HLT) break;
            case (prog[k][31:26])
                ADDI: begin dst = rt; val = r[rs] + {{16{prog[k][15]}}, prog[k][15:0]}; end
                ADD:  begin dst = rd; val = r[rs] + r[rt]; end
                OR:   begin dst = rd; val = r[rs] | r[rt]; end
                default: dst = 0;
            endcase
            if (dst != 0) r[dst] = val;
        end
        for (int i = 0; i < DC; i++) dv[i] = r[i];
    endfunction

    // Monitor: pops expectations whenever the DUT presents a write or a dump handshake.
    initial begin : monitor
        logic stall_prev;
        logic [31:0] prev_d;
        logic [4:0] prev_i;
        wr_t w;
        wrb_t wb;
        dp_t e;
        stall_prev = 1'b0;
        prev_d = '0;
        prev_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (core_init) init_cnt++;
                if (core_run) run_cnt++;
                if (b_core_init) b_init_cnt++;
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", {22'd0, mem_addr, mem_wdata}, 64'hdead);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", 64'(mem_addr), 64'(w.a));
                        chk("wr_data", 64'(mem_wdata), 64'(w.d));
                    end
                end
                if (b_mem_we) begin
                    if (exp_wr_b.size() == 0) begin
                        chk("ovf_unexpected_write", {29'd0, b_mem_addr, b_mem_wdata}, 64'hdead);
                    end else begin
                        wb = exp_wr_b.pop_front();
                        chk("ovf_wr", {29'd0, b_mem_addr, b_mem_wdata}, {29'd0, wb.a, wb.d});
                    end
                end
                if (out_valid) begin
                    if (stall_prev) chk("hold_stable", {27'd0, out_idx, out_data}, {27'd0, prev_i, prev_d});
                    if (out_ready) begin
                        if (exp_dump.size() == 0) begin
                            chk("unexpected_dump", {27'd0, out_idx, out_data}, 64'hdead);
                        end else begin
                            e = exp_dump.pop_front();
                            chk("dump_idx", 64'(out_idx), 64'(e.i));
                            chk("dump_data", 64'(out_data), 64'(e.d));
                        end
                    end
                    stall_prev = !out_ready;
                    prev_d = out_data;
                    prev_i = out_idx;
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    // Sink: optionally holds out_ready low for five cycles on every dump word.
    initial begin : sink
        int hold;
        hold = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                out_ready = 1'b1;
            end else if (out_valid) begin
                if (hold < 5) begin out_ready = 1'b0; hold++; end
                else out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
                hold = 0;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rst_ctrl"},
            64'({in_ready, mem_we, core_init, core_run, out_valid, busy, done, err, reg_raddr, out_idx, mem_addr}),
            64'd0);
        chk({tag, "_rst_data"}, {mem_wdata, out_data}, 64'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 20);
        if (!in_ready) note_fail("in_ready_wait");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_wr.delete();
        exp_dump.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // mode 0: run to DONE; mode 1: reset once the first dump word appears; mode 2: start pulses in RUN/OUT.
    task automatic run_prog(input logic [31:0] prog[$], input logic [31:0] ev[DC], input logic gaps,
                            input logic bp, input logic hold, input logic [1:0] exp_err, input int mode);
        int base_init, base_run, n;
        base_init = init_cnt;
        base_run  = run_cnt;
        bp_mode   = bp;
        hold_low  = hold;
        foreach (prog[k]) exp_wr.push_back('{a: AW'(k), d: prog[k]});
        for (int i = 0; i < DC; i++) exp_dump.push_back('{i: 5'(i), d: ev[i]});
        pulse_start();
        foreach (prog[k]) begin
            if (gaps) begin in_valid = 1'b0; @(posedge clk); #1; end
            send_word(prog[k], k == prog.size() - 1);
        end
        if (mode == 2) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!core_run && n < 50);
            if (!core_run) note_fail("core_run_wait");
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            chk("run_start_ignored", 64'({busy, core_run}), 64'(2'b11));
            chk("run_addr_kept", 64'(mem_addr), 64'(prog.size()));
        end
        if (mode != 0) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 200);
            if (!out_valid) note_fail("out_valid_wait");
        end
        if (mode == 1) begin
            #1 rst_n = 1'b0;
            #1 chk_reset_outputs("out");
            exp_wr.delete();
            exp_dump.delete();
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        if (mode == 2) begin
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            chk("out_start_ignored", 64'({out_valid, busy, out_idx}), 64'({1'b1, 1'b1, 5'd0}));
            chk("out_addr_kept", 64'(mem_addr), 64'(prog.size()));
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 3000);
        if (!done) note_fail("done_wait");
        chk("end_err", 64'(err), 64'(exp_err));
        chk("init_pulses", 64'(init_cnt - base_init), 64'd1);
        chk("wr_queue_left", 64'(exp_wr.size()), 64'd0);
        chk("dump_queue_left", 64'(exp_dump.size()), 64'd0);
        if (hold) chk("run_cycles", 64'(run_cnt - base_run), 64'(TO));
        @(posedge clk); #1;
    endtask

    initial begin : stim
        logic [31:0] nom[$];
        logic [31:0] prog[$];
        logic [31:0] ev_nom[DC];
        logic [31:0] ev[DC];
        int n, sel;
        logic [4:0] rs, rt, rd;

        start = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 32'd0; b_in_last = 1'b0;
        nom = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        ev_nom = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_prog(nom, ev_nom, 1'b0, 1'b0, 1'b0, ERR_NONE, 0);
        run_prog(nom, ev_nom, 1'b1, 1'b1, 1'b0, ERR_NONE, 0);

        // Overflow on the 8-word instance: the 9th word must never be accepted.
        for (int k = 0; k < 8; k++) exp_wr_b.push_back('{a: 3'(k), d: 32'h1000 + 32'(k)});
        @(posedge clk); #1; b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = 32'h1000 + 32'(k);
            n = 0;
            do begin @(negedge clk); n++; end while (!b_in_ready && n < 3);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_err_done", 64'({b_err, b_done, b_busy}), 64'({ERR_OVF, 1'b1, 1'b0}));
        chk("ovf_no_init", 64'(b_init_cnt), 64'd0);
        chk("ovf_writes_left", 64'(exp_wr_b.size()), 64'd0);

        run_prog(nom, ev_nom, 1'b0, 1'b0, 1'b1, ERR_TIMEOUT, 0);
        hold_low = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("done_start_clears_err", 64'({err, busy, in_ready}), 64'({ERR_NONE, 1'b1, 1'b1}));
        apply_reset();

        // Reset while the third program word is being offered.
        exp_wr.push_back('{a: AW'(0), d: nom[0]});
        exp_wr.push_back('{a: AW'(1), d: nom[1]});
        pulse_start();
        send_word(nom[0], 1'b0);
        send_word(nom[1], 1'b0);
        in_valid = 1'b1;
        in_data  = nom[2];
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("load");
        exp_wr.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("post_reset_idle", 64'({busy, done, in_ready, mem_we}), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        run_prog(nom, ev_nom, 1'b0, 1'b0, 1'b0, ERR_NONE, 0);

        run_prog(nom, ev_nom, 1'b0, 1'b1, 1'b0, ERR_NONE, 1);
        run_prog(nom, ev_nom, 1'b1, 1'b0, 1'b0, ERR_NONE, 0);
        run_prog(nom, ev_nom, 1'b0, 1'b1, 1'b0, ERR_NONE, 2);

        for (int t = 0; t < 8; t++) begin
            prog.delete();
            n = $urandom_range(3, 12);
            for (int k = 0; k < n; k++) begin
                sel = $urandom_range(0, 2);
                rs  = 5'($urandom_range(0, 5));
                rt  = 5'($urandom_range(1, 5));
                rd  = 5'($urandom_range(1, 5));
                case (sel)
                    0:       prog.push_back({ADDI, rs, rt, 16'($urandom)});
                    1:       prog.push_back({ADD, rs, rt, rd, 11'd0});
                    default: prog.push_back({OR, rs, rt, rd, 11'd0});
                endcase
            end
            prog.push_back(32'hfc000000);
            ref_run(prog, ev);
            run_prog(prog, ev, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, ERR_NONE, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
